// File: rtl/station_arbiter.sv
// station_arbiter: shares one station between two interfaces with round-robin
// ownership, same-user concurrent sharing and a per-grant hold timeout.
module station_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ie1_req,
    input  logic       ie2_req,
    input  logic [2:0] ie1_user,
    input  logic [2:0] ie2_user,
    input  logic       ie1_rel,
    input  logic       ie2_rel,
    output logic       ie1_gnt,
    output logic       ie2_gnt,
    output logic       shared,
    output logic [2:0] owner_user,
    output logic       timeout_p
);
    typedef enum logic [1:0] {IDLE, GNT1, GNT2, SHARED} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0] owner_nx;
    logic last, last_nx, primary, primary_nx;  // 0 = ie1, 1 = ie2
    logic lock1, lock2, set1, set2, to_nx;
    logic same, el1, el2, drop1, drop2, at_limit;
    assign same = ie1_user[2:1] == ie2_user[2:1] && (ie1_user[2] || (ie1_user[0] && ie2_user[0]));
    assign el1 = ie1_req && !lock1;
    assign el2 = ie2_req && !lock2;
    assign drop1 = ie1_rel || !ie1_req;
    assign drop2 = ie2_rel || !ie2_req;
    assign at_limit = cnt == CNT_W'(TIMEOUT - 1);
    assign ie1_gnt = state == GNT1 || state == SHARED;
    assign ie2_gnt = state == GNT2 || state == SHARED;
    assign shared = state == SHARED;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + CNT_W'(1);
        last_nx = last;
        primary_nx = primary;
        owner_nx = owner_user;
        to_nx = 1'b0;
        set1 = 1'b0;
        set2 = 1'b0;
        case (state)
            IDLE: begin
                if (el1 && (!el2 || last)) begin
                    state_nx = GNT1;
                    last_nx = 1'b0;
                    owner_nx = ie1_user;
                end else if (el2) begin
                    state_nx = GNT2;
                    last_nx = 1'b1;
                    owner_nx = ie2_user;
                end
            end
            GNT1: begin
                if (drop1) state_nx = IDLE;
                else if (el2 && same) begin
                    state_nx = SHARED;
                    primary_nx = 1'b0;
                end else if (at_limit) begin
                    state_nx = IDLE;
                    to_nx = 1'b1;
                    set1 = 1'b1;
                end
            end
            GNT2: begin
                if (drop2) state_nx = IDLE;
                else if (el1 && same) begin
                    state_nx = SHARED;
                    primary_nx = 1'b1;
                end else if (at_limit) begin
                    state_nx = IDLE;
                    to_nx = 1'b1;
                    set2 = 1'b1;
                end
            end
            SHARED: begin
                if (drop1 && drop2) state_nx = IDLE;
                else if (drop1) begin
                    state_nx = GNT2;
                    cnt_nx = '0;
                    owner_nx = ie2_user;
                end else if (drop2) begin
                    state_nx = GNT1;
                    cnt_nx = '0;
                    owner_nx = ie1_user;
                end else if (!same) state_nx = primary ? GNT2 : GNT1;
                else if (at_limit) begin
                    state_nx = IDLE;
                    to_nx = 1'b1;
                    set1 = 1'b1;
                    set2 = 1'b1;
                end
            end
        endcase
        // a fresh grant out of IDLE starts from 0 because IDLE holds the counter there
        if (state_nx == IDLE || state == IDLE) cnt_nx = '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            last <= 1'b1;
            primary <= 1'b0;
            lock1 <= 1'b0;
            lock2 <= 1'b0;
            owner_user <= 3'b000;
            timeout_p <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            last <= last_nx;
            primary <= primary_nx;
            lock1 <= set1 || (lock1 && ie1_req);
            lock2 <= set2 || (lock2 && ie2_req);
            owner_user <= owner_nx;
            timeout_p <= to_nx;
        end
    end
endmodule
